scratchpad_arbiter: RTL

//  Shares the single-port 1024x32 scratchpad between the execution pipeline and a host-side port (PCIe/readback DMA).
//  The exe pipeline cannot stall, so it has absolute priority. Host accesses are buffered and slipped into idle cycles.

---
 rtl/scratchpad_arbiter_if.sv | 45 ++++
 rtl/scratchpad_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/scratchpad_arbiter_if.sv
// Exe, host and SRAM-side signal bundle for the scratchpad arbiter.
// slave = arbiter side; master = environment (exe pipeline, host port, SRAM).
interface scratchpad_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  exe_mem_wen;
    logic                  exe_mem_ren;
    logic [ADDR_WIDTH-1:0] exe_mem_addr;
    logic [DATA_WIDTH-1:0] exe_mem_wdata;
    logic [DATA_WIDTH-1:0] exe_mem_rdata;

    logic                  host_valid;
    logic                  host_ready;
    logic                  host_we;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0] host_wdata;
    logic                  host_rvalid;
    logic [DATA_WIDTH-1:0] host_rdata;
    logic                  host_starved;

    logic                  sp_wen;
    logic                  sp_ren;
    logic [ADDR_WIDTH-1:0] sp_addr;
    logic [DATA_WIDTH-1:0] sp_wdata;
    logic [DATA_WIDTH-1:0] sp_rdata;

    modport slave (
        input  exe_mem_wen, exe_mem_ren, exe_mem_addr, exe_mem_wdata,
        output exe_mem_rdata,
        input  host_valid, host_we, host_addr, host_wdata,
        output host_ready, host_rvalid, host_rdata, host_starved,
        output sp_wen, sp_ren, sp_addr, sp_wdata,
        input  sp_rdata
    );

    modport master (
        output exe_mem_wen, exe_mem_ren, exe_mem_addr, exe_mem_wdata,
        input  exe_mem_rdata,
        output host_valid, host_we, host_addr, host_wdata,
        input  host_ready, host_rvalid, host_rdata, host_starved,
        input  sp_wen, sp_ren, sp_addr, sp_wdata,
        output sp_rdata
    );
endinterface

// File: rtl/scratchpad_arbiter.sv
// Shares the single-port scratchpad: exe pipeline always wins, host requests slip into idle cycles.
// Latency: exe 0 cycles to SRAM; host accept N, issue N+1 (exe idle), rvalid N+2. Optional SCRATCHPAD_ARB_PERF_EN.
// Backpressure: exe never stalls; host_ready drops while the 1-entry pending buffer is occupied.
module scratchpad_arbiter #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int WAIT_CNT_WIDTH = 8,
    parameter int STARVE_LIMIT   = 64
) (
    input  logic                clk,
    input  logic                rst,
    scratchpad_arbiter_if.slave bus,
    output logic [31:0]         perf_conflict
);
    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } host_req_t;

    localparam logic [WAIT_CNT_WIDTH-1:0] STARVE_LIM_W = WAIT_CNT_WIDTH'(STARVE_LIMIT);

    host_req_t                 pend_req;
    logic                      pend;
    logic                      host_ready_q;
    logic                      rd_owner_host;
    logic                      starved_q;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt;

    logic                      exe_active;
    logic                      host_accept;
    logic                      host_issue;
    logic                      pend_nxt;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt_nxt;

    assign exe_active  = bus.exe_mem_wen | bus.exe_mem_ren;
    assign host_accept = bus.host_valid & host_ready_q;
    assign host_issue  = pend & ~exe_active;
    assign pend_nxt    = host_accept | (pend & ~host_issue);

    always_comb begin
        bus.sp_wen   = bus.exe_mem_wen;
        bus.sp_ren   = bus.exe_mem_ren;
        bus.sp_addr  = bus.exe_mem_addr;
        bus.sp_wdata = bus.exe_mem_wdata;
        if (host_issue) begin
            bus.sp_wen   = pend_req.we;
            bus.sp_ren   = ~pend_req.we;
            bus.sp_addr  = pend_req.addr;
            bus.sp_wdata = pend_req.wdata;
        end
    end

    // Saturating: a counter that wrapped would silently drop host_starved.
    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (host_accept) begin
            wait_cnt_nxt = '0;
        end else if (pend && exe_active && (wait_cnt != '1)) begin
            wait_cnt_nxt = wait_cnt + WAIT_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend          <= 1'b0;
            pend_req      <= '0;
            host_ready_q  <= 1'b1;
            rd_owner_host <= 1'b0;
            wait_cnt      <= '0;
            starved_q     <= 1'b0;
        end else begin
            pend          <= pend_nxt;
            host_ready_q  <= ~pend_nxt;
            rd_owner_host <= host_issue & ~pend_req.we;
            wait_cnt      <= wait_cnt_nxt;
            starved_q     <= pend_nxt && (wait_cnt_nxt >= STARVE_LIM_W);
            if (host_accept) begin
                pend_req <= '{we: bus.host_we, addr: bus.host_addr, wdata: bus.host_wdata};
            end
        end
    end

    assign bus.host_ready    = host_ready_q;
    assign bus.host_rvalid   = rd_owner_host;
    assign bus.host_rdata    = bus.sp_rdata;
    assign bus.exe_mem_rdata = bus.sp_rdata;
    assign bus.host_starved  = starved_q;

`ifdef SCRATCHPAD_ARB_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= 32'd0;
        end else if (pend && exe_active) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_conflict = perf_q;
`else
    assign perf_conflict = 32'd0;
`endif
endmodule
